// File: rtl/cam_sensor_emulator.sv
// Parallel video source standing in for an MT9V034 sensor.
// It emits FRAME_VALID, LINE_VALID and 10-bit DATA with exact blanking and
// selectable test patterns. Every output comes from a flop and is computed from
// next-state values, so it changes on the same edge as the state that it reflects.
module cam_sensor_emulator #(
  parameter int unsigned H        = 752,
  parameter int unsigned V        = 480,
  parameter int unsigned HBLANK   = 94,
  parameter int unsigned FV_LEAD  = 4,
  parameter int unsigned FV_TRAIL = 4,
  parameter int unsigned VBLANK   = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [1:0] PATTERN,
  output logic       FRAME_VALID,
  output logic       LINE_VALID,
  output logic [9:0] DATA,
  output logic       FRAME_DONE,
  output logic [7:0] FRAME_COUNT
);

  localparam int unsigned ColW  = $clog2(H);
  localparam int unsigned RowW  = (V > 1) ? $clog2(V) : 1;
  localparam int unsigned Max01 = (FV_LEAD > HBLANK) ? FV_LEAD : HBLANK;
  localparam int unsigned Max23 = (FV_TRAIL > VBLANK) ? FV_TRAIL : VBLANK;
  localparam int unsigned CntMx = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned CntW  = $clog2(CntMx + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFvLead,
    StLine,
    StHblank,
    StFvTrail,
    StVbl
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [1:0]        pat_q, pat_d;
  logic [7:0]        fc_q, fc_d;
  logic [7:0]        count_q, count_d;
  logic              fv_q, fv_d;
  logic              lv_q, lv_d;
  logic              done_q, done_d;
  logic [9:0]        data_q, data_d;
  logic [9:0]        col10, row10;

  // Next-state sequencing of the frame timing; blanking counters restart at 0 on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    pat_d   = pat_q;
    fc_d    = fc_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (ENABLE) begin
          state_d = StFvLead;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          pat_d   = PATTERN;
          fc_d    = count_q;
        end
      end
      StFvLead: begin
        if (cnt_q == CntW'(FV_LEAD - 1)) begin
          state_d = StLine;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLine: begin
        if (col_q == ColW'(H - 1)) begin
          cnt_d = '0;
          if (row_q == RowW'(V - 1)) begin
            state_d = StFvTrail;
          end else begin
            state_d = StHblank;
            row_d   = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StHblank: begin
        if (cnt_q == CntW'(HBLANK - 1)) begin
          state_d = StLine;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFvTrail: begin
        if (cnt_q == CntW'(FV_TRAIL - 1)) begin
          state_d = StVbl;
          cnt_d   = '0;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StVbl: begin
        if (cnt_q == CntW'(VBLANK - 1)) begin
          cnt_d = '0;
          if (ENABLE) begin
            state_d = StFvLead;
            col_d   = '0;
            row_d   = '0;
            pat_d   = PATTERN;
            fc_d    = count_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output values for the cycle that follows, derived from the next state.
  always_comb begin
    col10  = 10'(col_d);
    row10  = 10'(row_d);
    fv_d   = (state_d == StFvLead) || (state_d == StLine) ||
             (state_d == StHblank) || (state_d == StFvTrail);
    lv_d   = (state_d == StLine);
    done_d = (state_d == StVbl) && (state_q != StVbl);
    data_d = '0;
    if (lv_d) begin
      unique case (pat_d)
        2'd0: data_d = col10;
        2'd1: data_d = row10;
        2'd2: data_d = (col10[3] ^ row10[3]) ? 10'h3FF : 10'h000;
        2'd3: data_d = col10 + row10 + {2'b00, fc_d};
        default: data_d = '0;
      endcase
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pat_q   <= '0;
      fc_q    <= '0;
      count_q <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      fc_q    <= fc_d;
      count_q <= count_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign FRAME_VALID = fv_q;
  assign LINE_VALID  = lv_q;
  assign DATA        = data_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_COUNT = count_q;

endmodule
